arcade_input_mapper: RTL and testbench
======================================

Name: arcade_input_mapper

Overview:
- Parametrised keyboard/joystick-to-cabinet input mapper, instanced in the emu top-level between hps_io and the arcade core.
- Replaces per-core ad-hoc button registers.
- Decodes the 65-bit ps2_key event bus into per-player key state and merges it with per-player joystick words.
- Applies screen-rotation direction remapping, per-button autofire, and timed coin pulses.
- All outputs are active-high. The core inverts them where it needs active-low.

Parameters:
- PLAYERS, 2: number of players, 1..4.
- BUTTONS, 4: action buttons per player, 1..4.
- COIN_PULSE, 16'd50000: coin output pulse length in clk_sys cycles, ≥1.
- AUTOFIRE_DIV, 20'd400000: clk_sys cycles per autofire half-period, ≥1.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ps2_key  in  65  hps_io key bus: [64] toggle, [7:0] code, [15:8]==F0 release, E0 prefix marks extended.
- joy_in  in  16*PLAYERS  per-player joystick word. Bits: [0]R [1]L [2]D [3]U [4+b] button b [8] start [9] coin.
- merge_joys  in  1  1 = OR all joy_in words into player 0 (single-player cores).
- rotate  in  2  0 none, 1 CW, 2 CCW, 3 treated as 0.
- coin_on_start  in  1  1 = start press also raises that player's coin.
- autofire_en  in  BUTTONS  per-button autofire enable, shared by all players.
- dir_out  out  4*PLAYERS  per player {U,D,L,R}.
- btn_out  out  BUTTONS*PLAYERS  player p, button b at index p*BUTTONS+b.
- start_out  out  PLAYERS  start held.
- coin_out  out  PLAYERS  coin pulse.

Behaviour:
- Reset: all outputs 0. Key state, toggle tracker, autofire counter/phase and coin timers are cleared. Reset mid-pulse aborts the pulse.
- Key event: registered old_toggle. An event occurs when ps2_key[64] != old_toggle.
  - pressed = (ps2_key[15:8] != F0).
  - extended: if pressed, ps2_key[15:8]==E0; otherwise ps2_key[23:16]==E0.
  - ps2_key[63:24] nonzero means the event is ignored (PrtScr/Pause).
- Key map. Directions match with or without the extended prefix (cursor and numpad both work). All other keys require the non-extended code.
  - P0: U 75, D 72, L 6B, R 74. Buttons 0..3: 14 Ctrl, 11 Alt, 29 Space, 12 Shift. Start 16 ('1') or 05 (F1). Coin 2E ('5').
  - P1: U 2D, D 2B, L 23, R 34. Buttons 0..3: 1C, 1B, 15, 1D. Start 1E ('2') or 06 (F2). Coin 36 ('6').
  - P2/P3: joystick only.
- Key state latches pressed/released on the event cycle and holds between events.
- Raw per player = key state OR joy_in. With merge_joys=1, player 0 takes the OR of all joy words and players ≥1 take keyboard only.
- Rotation, with raw {U,D,L,R} to output:
  - CW: U←L, D←R, L←D, R←U.
  - CCW: U←R, D←L, L←U, R←D.
- Autofire:
  - A counter counts to AUTOFIRE_DIV-1, wraps, and toggles phase. It is free-running from reset.
  - With autofire_en[b]=1: btn_out = raw & phase. Otherwise btn_out = raw.
- Coin, per player:
  - Request = raw coin, OR (raw start & coin_on_start).
  - FSM states: IDLE, PULSE, WAIT_REL.
  - IDLE → PULSE on request rising edge, with the timer loaded to COIN_PULSE-1 and coin_out=1.
  - PULSE decrements the timer. At 0 it moves to WAIT_REL when the request is still high, otherwise to IDLE.
  - WAIT_REL → IDLE when the request is low.
  - A new edge during PULSE is ignored. Holding the request produces exactly one pulse.
- Latency: every output is registered, 1 clk_sys after key-state or joy_in change. A key event is visible 2 cycles after the toggle flips.
- Key and joystick sources for the same bit OR together. Simultaneous press/release of different keys cannot happen, since there is one event per toggle.

Decomposition:
- Package input_map_pkg holds:
  - scancode localparams;
  - joystick bit indices (JB_R..JB_COIN);
  - rotate encodings (ROT_NONE/CW/CCW);
  - coin FSM state enum.
- Sub-module coin_pulser (request in, coin out, COIN_PULSE parameter), generated once per player.
- Decode, rotation and autofire stay in the top block.

Test Plan:
- Reset with reset_n=0 while joy_in all ones → all outputs 0. Release → outputs follow joy_in 1 cycle later.
- Toggle ps2_key with code 75, then 75 with E0, then F0 75 release, rotate=0 → dir_out[3] (P0 U) goes 1, stays 1, then goes 0.
- rotate=1, P0 left held (6B) → dir_out[3:0]=4'b1000. rotate=2, same key → 4'b0100.
- COIN_PULSE=4, key 2E held 20 cycles → coin_out[0] high exactly 4 cycles, one pulse. Release and press again → second pulse. Reset asserted mid-pulse → coin_out drops at once.
- AUTOFIRE_DIV=3, autofire_en=4'b0001, Ctrl held → btn_out[0] square wave 3 high/3 low. btn_out[1] unaffected.
- merge_joys=1, joy_in P1 bit 4 set → btn_out[0]=1, btn_out[BUTTONS]=0. coin_on_start=1 with P1 start bit 8 set → coin_out[0] pulses.

Source files
------------

// File: rtl/input_map_pkg.sv
// Shared scancodes, joystick bit layout, rotate encodings and coin FSM states
// for the arcade input mapper and its coin pulse generator.
package input_map_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_REL = 8'hF0;

  localparam logic [7:0] SC_P0_U        = 8'h75;
  localparam logic [7:0] SC_P0_D        = 8'h72;
  localparam logic [7:0] SC_P0_L        = 8'h6B;
  localparam logic [7:0] SC_P0_R        = 8'h74;
  localparam logic [7:0] SC_P0_B0       = 8'h14;
  localparam logic [7:0] SC_P0_B1       = 8'h11;
  localparam logic [7:0] SC_P0_B2       = 8'h29;
  localparam logic [7:0] SC_P0_B3       = 8'h12;
  localparam logic [7:0] SC_P0_START    = 8'h16;
  localparam logic [7:0] SC_P0_START_FN = 8'h05;
  localparam logic [7:0] SC_P0_COIN     = 8'h2E;

  localparam logic [7:0] SC_P1_U        = 8'h2D;
  localparam logic [7:0] SC_P1_D        = 8'h2B;
  localparam logic [7:0] SC_P1_L        = 8'h23;
  localparam logic [7:0] SC_P1_R        = 8'h34;
  localparam logic [7:0] SC_P1_B0       = 8'h1C;
  localparam logic [7:0] SC_P1_B1       = 8'h1B;
  localparam logic [7:0] SC_P1_B2       = 8'h15;
  localparam logic [7:0] SC_P1_B3       = 8'h1D;
  localparam logic [7:0] SC_P1_START    = 8'h1E;
  localparam logic [7:0] SC_P1_START_FN = 8'h06;
  localparam logic [7:0] SC_P1_COIN     = 8'h36;

  localparam int JB_R     = 0;
  localparam int JB_L     = 1;
  localparam int JB_D     = 2;
  localparam int JB_U     = 3;
  localparam int JB_BTN   = 4;
  localparam int JB_START = 8;
  localparam int JB_COIN  = 9;

  localparam logic [1:0] ROT_NONE = 2'd0;
  localparam logic [1:0] ROT_CW   = 2'd1;
  localparam logic [1:0] ROT_CCW  = 2'd2;

  typedef enum logic [1:0] {
    CS_IDLE     = 2'd0,
    CS_PULSE    = 2'd1,
    CS_WAIT_REL = 2'd2
  } coin_state_e;

  // Which joystick-word bits a scancode drives for keyboard player 0 or 1.
  // Directions ignore the E0 prefix so cursor keys and numpad both work.
  function automatic logic [15:0] key_hit(input logic player, input logic [7:0] code,
                                          input logic ext);
    logic [15:0] hit;
    hit = '0;
    if (!player) begin
      case (code)
        SC_P0_U: hit[JB_U] = 1'b1;
        SC_P0_D: hit[JB_D] = 1'b1;
        SC_P0_L: hit[JB_L] = 1'b1;
        SC_P0_R: hit[JB_R] = 1'b1;
        default: ;
      endcase
      if (!ext) begin
        case (code)
          SC_P0_B0:                    hit[JB_BTN+0] = 1'b1;
          SC_P0_B1:                    hit[JB_BTN+1] = 1'b1;
          SC_P0_B2:                    hit[JB_BTN+2] = 1'b1;
          SC_P0_B3:                    hit[JB_BTN+3] = 1'b1;
          SC_P0_START, SC_P0_START_FN: hit[JB_START] = 1'b1;
          SC_P0_COIN:                  hit[JB_COIN]  = 1'b1;
          default: ;
        endcase
      end
    end else begin
      case (code)
        SC_P1_U: hit[JB_U] = 1'b1;
        SC_P1_D: hit[JB_D] = 1'b1;
        SC_P1_L: hit[JB_L] = 1'b1;
        SC_P1_R: hit[JB_R] = 1'b1;
        default: ;
      endcase
      if (!ext) begin
        case (code)
          SC_P1_B0:                    hit[JB_BTN+0] = 1'b1;
          SC_P1_B1:                    hit[JB_BTN+1] = 1'b1;
          SC_P1_B2:                    hit[JB_BTN+2] = 1'b1;
          SC_P1_B3:                    hit[JB_BTN+3] = 1'b1;
          SC_P1_START, SC_P1_START_FN: hit[JB_START] = 1'b1;
          SC_P1_COIN:                  hit[JB_COIN]  = 1'b1;
          default: ;
        endcase
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/coin_pulser.sv
// Turns a coin request level into one fixed-length pulse per rising edge;
// a held request never retriggers until it has been released.
module coin_pulser
  import input_map_pkg::*;
#(
  parameter logic [15:0] COIN_PULSE = 16'd50000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req,
  output logic coin
);

  coin_state_e state_reg, state_next;
  logic [15:0] timer_reg, timer_next;
  logic        req_prev_reg;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    case (state_reg)
      CS_IDLE: begin
        if (req && !req_prev_reg) begin
          state_next = CS_PULSE;
          timer_next = COIN_PULSE - 16'd1;
        end
      end
      CS_PULSE: begin
        if (timer_reg == 16'd0) state_next = req ? CS_WAIT_REL : CS_IDLE;
        else                    timer_next = timer_reg - 16'd1;
      end
      CS_WAIT_REL: begin
        if (!req) state_next = CS_IDLE;
      end
      default: state_next = CS_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= CS_IDLE;
      timer_reg    <= '0;
      req_prev_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      req_prev_reg <= req;
    end
  end

  assign coin = (state_reg == CS_PULSE);

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges ps2_key keyboard state with joystick words into per-player cabinet
// inputs, with rotation remap, shared autofire and timed coin pulses.
module arcade_input_mapper
  import input_map_pkg::*;
#(
  parameter int          PLAYERS      = 2,
  parameter int          BUTTONS      = 4,
  parameter logic [15:0] COIN_PULSE   = 16'd50000,
  parameter logic [19:0] AUTOFIRE_DIV = 20'd400000
) (
  input  logic                         clk_sys,
  input  logic                         reset_n,
  input  logic [64:0]                  ps2_key,
  input  logic [16*PLAYERS-1:0]        joy_in,
  input  logic                         merge_joys,
  input  logic [1:0]                   rotate,
  input  logic                         coin_on_start,
  input  logic [BUTTONS-1:0]           autofire_en,
  output logic [4*PLAYERS-1:0]         dir_out,
  output logic [BUTTONS*PLAYERS-1:0]   btn_out,
  output logic [PLAYERS-1:0]           start_out,
  output logic [PLAYERS-1:0]           coin_out
);

  logic old_toggle_reg;
  logic key_pressed, key_ext, key_valid;

  // 63:24 nonzero marks multi-byte PrtScr/Pause sequences, which map to nothing.
  always_comb begin
    key_pressed = (ps2_key[15:8] != SC_REL);
    key_ext     = key_pressed ? (ps2_key[15:8] == SC_EXT) : (ps2_key[23:16] == SC_EXT);
    key_valid   = (ps2_key[64] != old_toggle_reg) && (ps2_key[63:24] == 40'd0);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) old_toggle_reg <= 1'b0;
    else          old_toggle_reg <= ps2_key[64];
  end

  logic [19:0] af_cnt_reg;
  logic        af_phase_reg;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt_reg   <= '0;
      af_phase_reg <= 1'b0;
    end else if (af_cnt_reg == AUTOFIRE_DIV - 20'd1) begin
      af_cnt_reg   <= '0;
      af_phase_reg <= ~af_phase_reg;
    end else begin
      af_cnt_reg   <= af_cnt_reg + 20'd1;
    end
  end

  logic [15:0] joy_or;

  always_comb begin
    joy_or = '0;
    for (int p = 0; p < PLAYERS; p++) joy_or = joy_or | joy_in[p*16 +: 16];
  end

  logic [15:0]                key_word [PLAYERS];
  logic [4*PLAYERS-1:0]       dir_next;
  logic [BUTTONS*PLAYERS-1:0] btn_next;
  logic [PLAYERS-1:0]         start_next;
  logic [PLAYERS-1:0]         coin_req;

  for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_player
    if (gi < 2) begin : g_kbd
      logic [15:0] key_state_reg;
      logic [15:0] hit;

      assign hit = key_hit(gi != 0, ps2_key[7:0], key_ext);

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)       key_state_reg <= '0;
        else if (key_valid) key_state_reg <= (key_state_reg & ~hit) | (hit & {16{key_pressed}});
      end

      assign key_word[gi] = key_state_reg;
    end else begin : g_no_kbd
      assign key_word[gi] = '0;
    end

    logic [15:0] joy_w, raw_w;
    logic [3:0]  dir_raw, dir_rot;
    logic        unused_raw;

    // In merged mode player 0 owns every joystick; the rest are keyboard-only.
    assign joy_w      = merge_joys ? ((gi == 0) ? joy_or : 16'h0) : joy_in[gi*16 +: 16];
    assign raw_w      = key_word[gi] | joy_w;
    assign unused_raw = ^raw_w;
    assign dir_raw    = raw_w[JB_U:JB_R];

    always_comb begin
      case (rotate)
        ROT_CW:  dir_rot = {dir_raw[1], dir_raw[0], dir_raw[2], dir_raw[3]};
        ROT_CCW: dir_rot = {dir_raw[0], dir_raw[1], dir_raw[3], dir_raw[2]};
        default: dir_rot = dir_raw;
      endcase
    end

    assign dir_next[gi*4 +: 4] = dir_rot;
    assign btn_next[gi*BUTTONS +: BUTTONS] =
        raw_w[JB_BTN +: BUTTONS] & (~autofire_en | {BUTTONS{af_phase_reg}});
    assign start_next[gi] = raw_w[JB_START];
    assign coin_req[gi]   = raw_w[JB_COIN] | (raw_w[JB_START] & coin_on_start);

    coin_pulser #(
      .COIN_PULSE (COIN_PULSE)
    ) u_coin (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .req     (coin_req[gi]),
      .coin    (coin_out[gi])
    );
  end

  logic [4*PLAYERS-1:0]       dir_reg;
  logic [BUTTONS*PLAYERS-1:0] btn_reg;
  logic [PLAYERS-1:0]         start_reg;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dir_reg   <= '0;
      btn_reg   <= '0;
      start_reg <= '0;
    end else begin
      dir_reg   <= dir_next;
      btn_reg   <= btn_next;
      start_reg <= start_next;
    end
  end

  assign dir_out   = dir_reg;
  assign btn_out   = btn_reg;
  assign start_out = start_reg;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: reset, key decode, rotation, coin
// pulses, autofire waveform and merged-joystick behaviour.
module tb_arcade_input_mapper;

  localparam int PLAYERS = 2;
  localparam int BUTTONS = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [64:0] ps2_key;
  logic [31:0] joy_in;
  logic        merge_joys;
  logic [1:0]  rotate;
  logic        coin_on_start;
  logic [3:0]  autofire_en;
  logic [7:0]  dir_out;
  logic [7:0]  btn_out;
  logic [1:0]  start_out;
  logic [1:0]  coin_out;

  arcade_input_mapper #(
    .PLAYERS      (PLAYERS),
    .BUTTONS      (BUTTONS),
    .COIN_PULSE   (16'd4),
    .AUTOFIRE_DIV (20'd3)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ps2_key       (ps2_key),
    .joy_in        (joy_in),
    .merge_joys    (merge_joys),
    .rotate        (rotate),
    .coin_on_start (coin_on_start),
    .autofire_en   (autofire_en),
    .dir_out       (dir_out),
    .btn_out       (btn_out),
    .start_out     (start_out),
    .coin_out      (coin_out)
  );

  always #5 clk_sys = ~clk_sys;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic tog = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic send_key(input logic [23:0] seq);
    tog     = ~tog;
    ps2_key = {tog, 40'h0, seq};
    $display("key event %h", seq);
  endtask

  int   highs, rises, ones1;
  logic prev;
  logic s0 [12];
  logic s1 [12];

  initial begin
    reset_n       = 1'b0;
    ps2_key       = '0;
    joy_in        = 32'hFFFF_FFFF;
    merge_joys    = 1'b0;
    rotate        = 2'd0;
    coin_on_start = 1'b0;
    autofire_en   = 4'b0000;

    tick(3);
    check_eq("rst_dir",   32'(dir_out),   32'h0);
    check_eq("rst_btn",   32'(btn_out),   32'h0);
    check_eq("rst_start", 32'(start_out), 32'h0);
    check_eq("rst_coin",  32'(coin_out),  32'h0);

    reset_n = 1'b1;
    tick(1);
    check_eq("joy_dir",   32'(dir_out),   32'hFF);
    check_eq("joy_btn",   32'(btn_out),   32'hFF);
    check_eq("joy_start", 32'(start_out), 32'h3);
    check_eq("joy_coin",  32'(coin_out),  32'h3);
    joy_in = '0;
    tick(1);
    check_eq("joy_clr_dir", 32'(dir_out), 32'h0);
    check_eq("joy_clr_btn", 32'(btn_out), 32'h0);
    tick(8);
    check_eq("joy_coin_end", 32'(coin_out), 32'h0);

    send_key(24'h000075);
    tick(1);
    check_eq("key_lat1", 32'(dir_out), 32'h0);
    tick(1);
    check_eq("key_up", 32'(dir_out), 32'h08);
    send_key(24'h00E075);
    tick(2);
    check_eq("key_up_ext", 32'(dir_out), 32'h08);
    send_key(24'h00F075);
    tick(2);
    check_eq("key_up_rel", 32'(dir_out), 32'h0);
    tog     = ~tog;
    ps2_key = {tog, 40'h1, 24'h000075};
    tick(2);
    check_eq("key_ignored", 32'(dir_out), 32'h0);
    send_key(24'h00E014);
    tick(2);
    check_eq("key_ext_btn", 32'(btn_out), 32'h0);

    rotate = 2'd1;
    send_key(24'h00006B);
    tick(2);
    check_eq("rot_cw",  32'(dir_out), 32'h08);
    rotate = 2'd2;
    tick(1);
    check_eq("rot_ccw", 32'(dir_out), 32'h04);
    rotate = 2'd3;
    tick(1);
    check_eq("rot_3",   32'(dir_out), 32'h02);
    rotate = 2'd0;
    send_key(24'h00F06B);
    tick(2);
    check_eq("rot_rel", 32'(dir_out), 32'h0);

    send_key(24'h00002E);
    highs = 0;
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (coin_out[0]) highs++;
      if (coin_out[0] && !prev) rises++;
      prev = coin_out[0];
    end
    check_eq("coin_len",   32'(highs), 32'd4);
    check_eq("coin_count", 32'(rises), 32'd1);
    check_eq("coin_p1",    32'(coin_out[1]), 32'h0);
    send_key(24'h00F02E);
    tick(2);
    check_eq("coin_rel", 32'(coin_out), 32'h0);
    send_key(24'h00002E);
    tick(2);
    check_eq("coin_second", 32'(coin_out), 32'h1);
    tick(1);
    reset_n = 1'b0;
    ps2_key = '0;
    tog     = 1'b0;
    #1;
    check_eq("coin_abort", 32'(coin_out), 32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(2);
    check_eq("coin_after_rst", 32'(coin_out), 32'h0);

    autofire_en = 4'b0001;
    send_key(24'h000014);
    tick(1);
    send_key(24'h000011);
    tick(3);
    for (int i = 0; i < 12; i++) begin
      s0[i] = btn_out[0];
      s1[i] = btn_out[1];
      tick(1);
    end
    highs = 0;
    ones1 = 0;
    for (int i = 0; i < 12; i++) begin
      if (s0[i]) highs++;
      if (s1[i]) ones1++;
    end
    for (int i = 0; i < 9; i++) check_eq($sformatf("af_half%0d", i), 32'(s0[i+3]), 32'(!s0[i]));
    check_eq("af_duty",  32'(highs), 32'd6);
    check_eq("af_btn1",  32'(ones1), 32'd12);
    send_key(24'h00F014);
    tick(1);
    send_key(24'h00F011);
    tick(2);
    autofire_en = 4'b0000;
    check_eq("af_rel", 32'(btn_out), 32'h0);

    merge_joys = 1'b1;
    joy_in     = 32'h0010_0000;
    tick(1);
    check_eq("merge_btn_p0", 32'(btn_out[0]), 32'h1);
    check_eq("merge_btn_p1", 32'(btn_out[BUTTONS]), 32'h0);
    coin_on_start = 1'b1;
    joy_in        = 32'h0100_0000;
    tick(1);
    check_eq("merge_coin",  32'(coin_out),  32'h1);
    check_eq("merge_start", 32'(start_out), 32'h1);
    send_key(24'h00001C);
    tick(2);
    check_eq("merge_p1_kbd", 32'(btn_out[BUTTONS]), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
